mesi_line_ctrl: RTL and testbench

MESI_LINE_CTRL -- requirements
Module: mesi_line_ctrl

---
 rtl/mesi_pkg.sv | 59 +++++
 rtl/mesi_next_state.sv | 53 +++++
 rtl/mesi_line_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mesi_line_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// mesi_pkg: shared encodings for the MESI line controller.
//   mesi_t       - line coherence state (M/E/S/I)
//   snp_t        - snoop result / snoop response code
//   bus_op_t     - bus operation code
//   ctrl_state_t - controller FSM states
//   CMD_*        - 4-bit trace command codes (7 and 10-15 are unused)
package mesi_pkg;

    localparam int OFFSET_W = 6;

    typedef enum logic [1:0] {
        MESI_M = 2'b00,
        MESI_E = 2'b01,
        MESI_S = 2'b10,
        MESI_I = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10
    } snp_t;

    typedef enum logic [1:0] {
        BUS_READ       = 2'd0,
        BUS_WRITE      = 2'd1,
        BUS_INVALIDATE = 2'd2,
        BUS_RFO        = 2'd3
    } bus_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRBACK,
        ST_BUSOP,
        ST_RESP,
        ST_CLEAR
    } ctrl_state_t;

    localparam logic [3:0] CMD_L1_READ   = 4'd0;
    localparam logic [3:0] CMD_L1_WRITE  = 4'd1;
    localparam logic [3:0] CMD_IFETCH    = 4'd2;
    localparam logic [3:0] CMD_SNP_INV   = 4'd3;
    localparam logic [3:0] CMD_SNP_READ  = 4'd4;
    localparam logic [3:0] CMD_SNP_WRITE = 4'd5;
    localparam logic [3:0] CMD_SNP_RFO   = 4'd6;
    localparam logic [3:0] CMD_CLEAR     = 4'd8;
    localparam logic [3:0] CMD_PRINT     = 4'd9;

    function automatic logic is_l1_cmd(input logic [3:0] c);
        return (c == CMD_L1_READ) || (c == CMD_L1_WRITE) || (c == CMD_IFETCH);
    endfunction

    function automatic logic is_snoop_cmd(input logic [3:0] c);
        return (c == CMD_SNP_INV) || (c == CMD_SNP_READ) ||
               (c == CMD_SNP_WRITE) || (c == CMD_SNP_RFO);
    endfunction

endpackage

// File: rtl/mesi_next_state.sv
// mesi_next_state: combinational MESI transition rules.
//   cur_state - present state of the addressed set
//   hit       - lookup result for the command address
//   cmd       - trace command code
//   snoop_in  - other caches' snoop result (only meaningful with a bus ack)
//   nxt_state - state the line takes when the command completes
//   rsp       - this cache's snoop response
module mesi_next_state
    import mesi_pkg::*;
(
    input  mesi_t       cur_state,
    input  logic        hit,
    input  logic [3:0]  cmd,
    input  logic [1:0]  snoop_in,
    output mesi_t       nxt_state,
    output snp_t        rsp
);

    always_comb begin
        nxt_state = cur_state;
        rsp       = SNP_NOHIT;
        case (cmd)
            CMD_L1_READ, CMD_IFETCH: begin
                if (!hit) begin
                    nxt_state = (snoop_in == SNP_HIT || snoop_in == SNP_HITM) ? MESI_S : MESI_E;
                end
            end
            CMD_L1_WRITE: nxt_state = MESI_M;
            CMD_SNP_INV: begin
                if (hit) begin
                    nxt_state = MESI_I;
                    rsp       = SNP_HIT;
                end
            end
            CMD_SNP_READ: begin
                if (hit) begin
                    nxt_state = MESI_S;
                    rsp       = (cur_state == MESI_M) ? SNP_HITM : SNP_HIT;
                end
            end
            CMD_SNP_WRITE, CMD_SNP_RFO: begin
                if (hit) begin
                    nxt_state = MESI_I;
                    rsp       = (cur_state == MESI_M) ? SNP_HITM : SNP_HIT;
                end
            end
            // clear is sequenced by the controller; print leaves everything alone
            CMD_CLEAR, CMD_PRINT: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/mesi_line_ctrl.sv
// mesi_line_ctrl: direct-mapped MESI line-state controller.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        - command handshake; cmd, cmd_addr latched on accept
//   bus_req/bus_op/bus_addr    - bus request, held until bus_ack
//   bus_ack, snoop_in          - bus completion and other caches' snoop result
//   snp_rsp_valid/snp_rsp      - snoop response, pulses with done for snoop commands
//   done, hit                  - one-cycle retire pulse and lookup result
// Optional macro STATS_EN adds hit_cnt/miss_cnt counters of L1 command outcomes.
module mesi_line_ctrl
    import mesi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_SETS = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              bus_req,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [1:0]        snoop_in,
    output logic              snp_rsp_valid,
    output logic [1:0]        snp_rsp,
    output logic              done,
    output logic              hit
`ifdef STATS_EN
   ,output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    ctrl_state_t       state_reg, state_next;
    logic [3:0]        cmd_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              hit_reg, hit_next;
    snp_t              rsp_reg, rsp_next;
    bus_op_t           op_reg, op_next;
    logic [IDX_W-1:0]  clr_idx_reg, clr_idx_next;

    logic              st_we, tag_we, clr_we;
    mesi_t             mesi_arr [NUM_SETS];
    logic [TAG_W-1:0]  tag_arr  [NUM_SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  addr_tag;
    mesi_t             cur_state, ns_state;
    snp_t              ns_rsp;
    logic              lookup_hit, ns_hit, cmd_is_l1, cmd_is_snp;
    logic [ADDR_W-1:0] victim_addr;

    assign idx         = addr_reg[OFFSET_W +: IDX_W];
    assign addr_tag    = addr_reg[ADDR_W-1 -: TAG_W];
    assign cur_state   = mesi_arr[idx];
    assign lookup_hit  = (tag_arr[idx] == addr_tag) && (cur_state != MESI_I);
    assign victim_addr = {tag_arr[idx], idx, {OFFSET_W{1'b0}}};
    assign cmd_is_l1   = is_l1_cmd(cmd_reg);
    assign cmd_is_snp  = is_snoop_cmd(cmd_reg);

    // The set is not rewritten between LOOKUP and bus completion, so the
    // stored hit is all the transition logic needs after LOOKUP.
    assign ns_hit = (state_reg == ST_LOOKUP) ? lookup_hit : hit_reg;

    mesi_next_state u_next_state (
        .cur_state (cur_state),
        .hit       (ns_hit),
        .cmd       (cmd_reg),
        .snoop_in  (snoop_in),
        .nxt_state (ns_state),
        .rsp       (ns_rsp)
    );

    // Per-set state and tag storage; reset puts every line in I with tag 0.
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
        mesi_t            mesi_reg;
        logic [TAG_W-1:0] tag_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mesi_reg <= MESI_I;
                tag_reg  <= '0;
            end else if (clr_we && clr_idx_reg == IDX_W'(gi)) begin
                mesi_reg <= MESI_I;
            end else if (st_we && idx == IDX_W'(gi)) begin
                mesi_reg <= ns_state;
                if (tag_we) begin
                    tag_reg <= addr_tag;
                end
            end
        end

        assign mesi_arr[gi] = mesi_reg;
        assign tag_arr[gi]  = tag_reg;
    end

    always_comb begin
        state_next    = state_reg;
        hit_next      = hit_reg;
        rsp_next      = rsp_reg;
        op_next       = op_reg;
        clr_idx_next  = clr_idx_reg;
        st_we         = 1'b0;
        tag_we        = 1'b0;
        clr_we        = 1'b0;
        cmd_ready     = 1'b0;
        bus_req       = 1'b0;
        bus_op        = op_reg;
        bus_addr      = addr_reg;
        done          = 1'b0;
        hit           = 1'b0;
        snp_rsp_valid = 1'b0;
        snp_rsp       = SNP_NOHIT;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_next     = (cmd_is_l1 || cmd_is_snp) && lookup_hit;
                rsp_next     = ns_rsp;
                clr_idx_next = '0;
                if (cmd_reg == CMD_CLEAR) begin
                    state_next = ST_CLEAR;
                end else if (cmd_is_l1 && !lookup_hit) begin
                    op_next    = (cmd_reg == CMD_L1_WRITE) ? BUS_RFO : BUS_READ;
                    // a dirty line being replaced is written back first
                    state_next = (cur_state == MESI_M) ? ST_WRBACK : ST_BUSOP;
                end else if (cmd_reg == CMD_L1_WRITE && cur_state == MESI_S) begin
                    op_next    = BUS_INVALIDATE;
                    state_next = ST_BUSOP;
                end else if (cmd_is_snp && lookup_hit && cur_state == MESI_M &&
                             cmd_reg != CMD_SNP_INV) begin
                    op_next    = BUS_WRITE;
                    state_next = ST_BUSOP;
                end else begin
                    // no bus traffic needed: commit the transition right away
                    st_we      = cmd_is_l1 || cmd_is_snp;
                    state_next = ST_RESP;
                end
            end
            ST_WRBACK: begin
                bus_req  = 1'b1;
                bus_op   = BUS_WRITE;
                bus_addr = victim_addr;
                if (bus_ack) begin
                    state_next = ST_BUSOP;
                end
            end
            ST_BUSOP: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    st_we      = 1'b1;
                    tag_we     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                done          = 1'b1;
                hit           = hit_reg;
                snp_rsp_valid = cmd_is_snp;
                if (cmd_is_snp) begin
                    snp_rsp = rsp_reg;
                end
                state_next    = ST_IDLE;
            end
            ST_CLEAR: begin
                clr_we       = 1'b1;
                clr_idx_next = clr_idx_reg + 1'b1;
                // retire in the same cycle the last set is cleared
                if (clr_idx_reg == IDX_W'(NUM_SETS - 1)) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cmd_reg     <= '0;
            addr_reg    <= '0;
            hit_reg     <= 1'b0;
            rsp_reg     <= SNP_NOHIT;
            op_reg      <= BUS_READ;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            hit_reg     <= hit_next;
            rsp_reg     <= rsp_next;
            op_reg      <= op_next;
            clr_idx_reg <= clr_idx_next;
            if (cmd_valid && cmd_ready) begin
                cmd_reg  <= cmd;
                addr_reg <= cmd_addr;
            end
        end
    end

`ifdef STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (done && cmd_is_l1) begin
            if (hit_reg) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end else begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// tb_mesi_line_ctrl: self-checking bench for mesi_line_ctrl (NUM_SETS=16, ADDR_W=32).
// Directed vector table, hand-written corner sequences, then random commands
// checked against a set-level reference model.
module tb_mesi_line_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd = 4'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic        bus_req;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [1:0]  snoop_in = 2'd0;
    logic        snp_rsp_valid;
    logic [1:0]  snp_rsp;
    logic        done;
    logic        hit;
`ifdef STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    mesi_line_ctrl #(.ADDR_W(32), .NUM_SETS(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .cmd_addr      (cmd_addr),
        .bus_req       (bus_req),
        .bus_op        (bus_op),
        .bus_addr      (bus_addr),
        .bus_ack       (bus_ack),
        .snoop_in      (snoop_in),
        .snp_rsp_valid (snp_rsp_valid),
        .snp_rsp       (snp_rsp),
        .done          (done),
        .hit           (hit)
`ifdef STATS_EN
       ,.hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int stable_err = 0;

    // observed result of the last command
    logic        r_done, r_hit, r_rv;
    logic [1:0]  r_rsp;
    int          r_lat, r_nops;
    logic [1:0]  r_op   [4];
    logic [31:0] r_addr [4];

    // reference model: per-set state (0=M 1=E 2=S 3=I) and tag
    int          m_st  [16];
    logic [21:0] m_tag [16];
    int          m_hits, m_miss;
    logic        e_hit, e_rv;
    logic [1:0]  e_rsp;
    int          e_n;
    logic [1:0]  e_op   [4];
    logic [31:0] e_addr [4];

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [1:0]  sn;
        logic        eh;
        logic        erv;
        logic [1:0]  ersp;
        int          enops;
        logic [1:0]  eop0;
        logic [31:0] ea0;
        logic [1:0]  eop1;
        logic [31:0] ea1;
        int          elat;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] sn, input int dly);
        int          waitc;
        bit          holding;
        logic [1:0]  hold_op;
        logic [31:0] hold_addr;
        waitc = 0; holding = 0; hold_op = '0; hold_addr = '0;
        r_done = 0; r_hit = 0; r_rv = 0; r_rsp = '0; r_lat = 0; r_nops = 0;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd = c; cmd_addr = a; snoop_in = sn; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 100 && !r_done; cyc++) begin
            if (done) begin
                r_done = 1; r_lat = cyc; r_hit = hit; r_rv = snp_rsp_valid; r_rsp = snp_rsp;
            end else if (bus_req) begin
                if (holding && (bus_op !== hold_op || bus_addr !== hold_addr)) stable_err++;
                if (!holding) begin
                    holding = 1; hold_op = bus_op; hold_addr = bus_addr; waitc = 0;
                end
                if (waitc >= dly) begin
                    bus_ack = 1'b1;
                    if (r_nops < 4) begin
                        r_op[r_nops] = bus_op; r_addr[r_nops] = bus_addr;
                    end
                    r_nops++;
                    holding = 0;
                end else begin
                    waitc++;
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        if (!r_done) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_timeout: cmd %0d addr 0x%08h no done seen, required done within 100 cycles", c, a);
        end
    endtask

    task automatic push_op(input logic [1:0] op, input logic [31:0] ad);
        if (e_n < 4) begin
            e_op[e_n] = op; e_addr[e_n] = ad;
        end
        e_n++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_st[i] = 3; m_tag[i] = '0;
        end
        m_hits = 0; m_miss = 0;
    endtask

    // Behaviour of one command on the model cache, straight from the MESI rules.
    task automatic model_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] sn);
        int          s;
        logic [21:0] t;
        logic [31:0] victim;
        logic        lh;
        s = int'(a[9:6]);
        t = a[31:10];
        victim = {m_tag[s], a[9:6], 6'd0};
        lh = (m_st[s] != 3) && (m_tag[s] == t);
        e_n = 0; e_hit = 0; e_rv = 0; e_rsp = 2'd0;
        case (c)
            4'd0, 4'd2: begin
                e_hit = lh;
                if (!lh) begin
                    if (m_st[s] == 0) push_op(2'd1, victim);
                    push_op(2'd0, a);
                    m_st[s] = (sn == 2'd1 || sn == 2'd2) ? 2 : 1;
                    m_tag[s] = t;
                end
            end
            4'd1: begin
                e_hit = lh;
                if (lh) begin
                    if (m_st[s] == 2) push_op(2'd2, a);
                end else begin
                    if (m_st[s] == 0) push_op(2'd1, victim);
                    push_op(2'd3, a);
                    m_tag[s] = t;
                end
                m_st[s] = 0;
            end
            4'd3, 4'd4, 4'd5, 4'd6: begin
                e_hit = lh;
                e_rv = 1;
                if (lh) begin
                    if (m_st[s] == 0 && c != 4'd3) begin
                        e_rsp = 2'd2;
                        push_op(2'd1, a);
                    end else begin
                        e_rsp = 2'd1;
                    end
                    m_st[s] = (c == 4'd4) ? 2 : 3;
                end
            end
            4'd8: begin
                for (int i = 0; i < 16; i++) m_st[i] = 3;
            end
            default: ;
        endcase
        if (c == 4'd0 || c == 4'd1 || c == 4'd2) begin
            if (lh) m_hits++;
            else    m_miss++;
        end
    endtask

    initial begin
        int bad;
        int got;
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [1:0]  rs;

        // directed table: {cmd, addr, snoop_in, hit, rsp_valid, rsp, nops, op0, addr0, op1, addr1, latency}
        tv[0]  = '{4'd0, 32'h0000_1040, 2'd0, 1'b0, 1'b0, 2'd0, 1, 2'd0, 32'h0000_1040, 2'd0, 32'h0, 3};
        tv[1]  = '{4'd1, 32'h0000_1040, 2'd0, 1'b1, 1'b0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[2]  = '{4'd4, 32'h0000_1040, 2'd0, 1'b1, 1'b1, 2'd2, 1, 2'd1, 32'h0000_1040, 2'd0, 32'h0, 3};
        tv[3]  = '{4'd1, 32'h0000_1040, 2'd0, 1'b1, 1'b0, 2'd0, 1, 2'd2, 32'h0000_1040, 2'd0, 32'h0, 3};
        tv[4]  = '{4'd0, 32'h0000_2040, 2'd1, 1'b0, 1'b0, 2'd0, 2, 2'd1, 32'h0000_1040, 2'd0, 32'h0000_2040, 4};
        tv[5]  = '{4'd4, 32'h0000_2040, 2'd0, 1'b1, 1'b1, 2'd1, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[6]  = '{4'd3, 32'h0000_2040, 2'd0, 1'b1, 1'b1, 2'd1, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[7]  = '{4'd4, 32'h0000_2040, 2'd0, 1'b0, 1'b1, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[8]  = '{4'd9, 32'h0000_2040, 2'd0, 1'b0, 1'b0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[9]  = '{4'd12, 32'h0000_2040, 2'd0, 1'b0, 1'b0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[10] = '{4'd1, 32'h0000_3080, 2'd0, 1'b0, 1'b0, 2'd0, 1, 2'd3, 32'h0000_3080, 2'd0, 32'h0, 3};
        tv[11] = '{4'd2, 32'h0000_1040, 2'd2, 1'b0, 1'b0, 2'd0, 1, 2'd0, 32'h0000_1040, 2'd0, 32'h0, 3};
        tv[12] = '{4'd4, 32'h0000_1040, 2'd0, 1'b1, 1'b1, 2'd1, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[13] = '{4'd5, 32'h0000_3080, 2'd0, 1'b1, 1'b1, 2'd2, 1, 2'd1, 32'h0000_3080, 2'd0, 32'h0, 3};
        tv[14] = '{4'd1, 32'h0000_3080, 2'd0, 1'b0, 1'b0, 2'd0, 1, 2'd3, 32'h0000_3080, 2'd0, 32'h0, 3};
        tv[15] = '{4'd8, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 17};
        tv[16] = '{4'd4, 32'h0000_3080, 2'd0, 1'b0, 1'b1, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[17] = '{4'd6, 32'h0000_1040, 2'd0, 1'b0, 1'b1, 2'd0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};
        tv[18] = '{4'd0, 32'h0000_1040, 2'd0, 1'b0, 1'b0, 2'd0, 1, 2'd0, 32'h0000_1040, 2'd0, 32'h0, 3};
        tv[19] = '{4'd6, 32'h0000_1040, 2'd0, 1'b1, 1'b1, 2'd1, 0, 2'd0, 32'h0, 2'd0, 32'h0, 2};

        // reset and reset-state outputs
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_snp_rsp_valid", {31'd0, snp_rsp_valid}, 32'd0);
        check("rst_snp_rsp", {30'd0, snp_rsp}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed vectors
        for (int i = 0; i < NV; i++) begin
            run_cmd(tv[i].c, tv[i].a, tv[i].sn, 0);
            $display("vec %0d: cmd %0d addr 0x%08h hit %0d rsp_valid %0d rsp %0d bus_ops %0d latency %0d",
                     i, tv[i].c, tv[i].a, r_hit, r_rv, r_rsp, r_nops, r_lat);
            check($sformatf("vec%0d_hit", i), {31'd0, r_hit}, {31'd0, tv[i].eh});
            check($sformatf("vec%0d_rsp_valid", i), {31'd0, r_rv}, {31'd0, tv[i].erv});
            if (tv[i].erv) check($sformatf("vec%0d_rsp", i), {30'd0, r_rsp}, {30'd0, tv[i].ersp});
            check($sformatf("vec%0d_nops", i), r_nops, tv[i].enops);
            if (tv[i].enops > 0 && r_nops > 0) begin
                check($sformatf("vec%0d_op0", i), {30'd0, r_op[0]}, {30'd0, tv[i].eop0});
                check($sformatf("vec%0d_addr0", i), r_addr[0], tv[i].ea0);
            end
            if (tv[i].enops > 1 && r_nops > 1) begin
                check($sformatf("vec%0d_op1", i), {30'd0, r_op[1]}, {30'd0, tv[i].eop1});
                check($sformatf("vec%0d_addr1", i), r_addr[1], tv[i].ea1);
            end
            check($sformatf("vec%0d_latency", i), r_lat, tv[i].elat);
        end

        // delayed ack: request must hold until acked
        run_cmd(4'd1, 32'h0000_4100, 2'd0, 3);
        $display("held: cmd 1 addr 0x00004100 bus_ops %0d latency %0d", r_nops, r_lat);
        check("held_latency", r_lat, 6);
        check("held_nops", r_nops, 1);
        if (r_nops > 0) check("held_op", {30'd0, r_op[0]}, 32'd3);

        // bus_ack while idle is ignored
        bad = 0;
        bus_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus_req || done || !cmd_ready) bad++;
        end
        bus_ack = 1'b0;
        check("idle_ack_ignored", bad, 0);
        run_cmd(4'd4, 32'h0000_4100, 2'd0, 0);
        $display("idle-ack follow-up: snoop read 0x00004100 rsp %0d bus_ops %0d", r_rsp, r_nops);
        check("idle_ack_followup_rsp", {30'd0, r_rsp}, 32'd2);
        check("idle_ack_followup_nops", r_nops, 1);

        // reset while a bus request is outstanding
        cmd = 4'd0; cmd_addr = 32'h0000_7340; snoop_in = 2'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            if (bus_req) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("midop_bus_req_seen", got, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midop_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("midop_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("midop_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("midop_rst_no_retire", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // random commands against the reference model
        for (int n = 0; n < 250; n++) begin
            rc = 4'($urandom_range(0, 15));
            if (rc == 4'd8 && $urandom_range(0, 3) != 0) rc = 4'd0;
            ra = {20'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
            rs = 2'($urandom_range(0, 2));
            model_cmd(rc, ra, rs);
            run_cmd(rc, ra, rs, int'($urandom_range(0, 2)));
            $display("txn %0d: cmd %0d addr 0x%08h snoop_in %0d hit %0d rsp_valid %0d rsp %0d bus_ops %0d latency %0d",
                     n, rc, ra, rs, r_hit, r_rv, r_rsp, r_nops, r_lat);
            check("rand_hit", {31'd0, r_hit}, {31'd0, e_hit});
            check("rand_rsp_valid", {31'd0, r_rv}, {31'd0, e_rv});
            if (e_rv) check("rand_rsp", {30'd0, r_rsp}, {30'd0, e_rsp});
            check("rand_nops", r_nops, e_n);
            for (int k = 0; k < e_n && k < r_nops && k < 4; k++) begin
                check("rand_op", {30'd0, r_op[k]}, {30'd0, e_op[k]});
                check("rand_addr", r_addr[k], e_addr[k]);
            end
        end

        check("bus_hold_stable", stable_err, 0);
`ifdef STATS_EN
        check("stats_hit_cnt", hit_cnt, m_hits);
        check("stats_miss_cnt", miss_cnt, m_miss);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
